// File: rtl/piece_queue_if.sv
// Bundle of the piece_queue signals shared by the RNG, the game FSM and the queue.
// The master drives the candidate stream and control; the slave returns the queue state.
interface piece_queue_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [1:0]    random;
    logic          clear;
    logic          take;
    logic [1:0]    piece;
    logic          piece_valid;
    logic [1:0]    preview;
    logic          preview_valid;
    logic [CW-1:0] fill_count;

    modport master (
        output random, clear, take,
        input  piece, piece_valid, preview, preview_valid, fill_count
    );

    modport slave (
        input  random, clear, take,
        output piece, piece_valid, preview, preview_valid, fill_count
    );
endinterface

// File: rtl/piece_queue.sv
// Next-piece scheduler: filters the RNG stream with a no-triple-repeat rule and
// buffers accepted piece IDs in a small FIFO, exposing head and preview.
module piece_queue #(
    parameter int DEPTH      = 4,
    parameter int MAX_REROLL = 3
) (
    input  logic       clka,
    input  logic       restart,
    piece_queue_if.slave q
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int RW = $clog2(MAX_REROLL + 1);
    localparam logic [CW-1:0] FULL  = CW'(DEPTH);
    localparam logic [RW-1:0] RRMAX = RW'(MAX_REROLL);

    typedef enum logic {FILL, RUN} state_t;

    state_t        state_q, state_d;
    logic [1:0]    mem_q [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [1:0]    h1_q, h1_d;
    logic [1:0]    h0_q, h0_d;
    logic [1:0]    hcnt_q, hcnt_d;
    logic [RW-1:0] rr_q, rr_d;

    logic          pieceValid;
    logic          previewValid;
    logic          canPush;
    logic          reject;
    logic          pushEn;
    logic          popEn;
    logic [1:0]    pushVal;

    assign pieceValid   = (state_q == RUN) && (count_q != '0);
    assign previewValid = (state_q == RUN) && (count_q >= CW'(2));
    assign canPush      = (count_q != FULL);
    assign reject       = (hcnt_q == 2'd2) && (q.random == h1_q) && (q.random == h0_q);

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        h1_d    = h1_q;
        h0_d    = h0_q;
        hcnt_d  = hcnt_q;
        rr_d    = rr_q;
        pushEn  = 1'b0;
        popEn   = 1'b0;
        pushVal = reject ? (q.random + 2'd1) : q.random;

        if (q.clear) begin
            state_d = FILL;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            hcnt_d  = '0;
            rr_d    = '0;
        end else begin
            popEn = q.take && pieceValid;
            // The re-roll counter only advances on cycles where a push was possible.
            if (canPush) begin
                if (reject && (rr_q != RRMAX)) begin
                    rr_d = rr_q + RW'(1);
                end else begin
                    pushEn = 1'b1;
                    rr_d   = '0;
                end
            end

            if (pushEn) begin
                tail_d = tail_q + PW'(1);
                h0_d   = h1_q;
                h1_d   = pushVal;
                if (hcnt_q != 2'd2) begin
                    hcnt_d = hcnt_q + 2'd1;
                end
            end
            if (popEn) begin
                head_d = head_q + PW'(1);
            end

            case ({pushEn, popEn})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase

            if ((state_q == FILL) && (count_d == FULL)) begin
                state_d = RUN;
            end
        end
    end

    always_ff @(posedge clka or posedge restart) begin
        if (restart) begin
            state_q <= FILL;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            h1_q    <= '0;
            h0_q    <= '0;
            hcnt_q  <= '0;
            rr_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            h1_q    <= h1_d;
            h0_q    <= h0_d;
            hcnt_q  <= hcnt_d;
            rr_q    <= rr_d;
            if (pushEn) begin
                mem_q[tail_q] <= pushVal;
            end
        end
    end

    assign q.piece         = pieceValid   ? mem_q[head_q] : 2'd0;
    assign q.preview       = previewValid ? mem_q[head_q + PW'(1)] : 2'd0;
    assign q.piece_valid   = pieceValid;
    assign q.preview_valid = previewValid;
    assign q.fill_count    = count_q;
endmodule

// File: tb/tb_piece_queue.sv
// Self-checking bench for piece_queue: a directed vector table plus hand-written
// sequences for re-roll forcing and asynchronous reset.
module tb_piece_queue;
    logic clka;
    logic restart;

    piece_queue_if #(.DEPTH(4)) bus ();

    piece_queue #(.DEPTH(4), .MAX_REROLL(3)) dut (
        .clka    (clka),
        .restart (restart),
        .q       (bus)
    );

    initial clka = 1'b0;
    always #5 clka = ~clka;

    typedef struct {
        logic [1:0] rnd;
        logic       clr;
        logic       tk;
        logic [1:0] ePiece;
        logic       ePv;
        logic [1:0] ePrev;
        logic       ePrevV;
        logic [2:0] eCnt;
    } vec_t;

    vec_t vecs [17];
    int   checks;
    int   failures;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    task automatic checkAll(input string tag, input logic [1:0] ePiece, input logic ePv,
                            input logic [1:0] ePrev, input logic ePrevV, input logic [2:0] eCnt);
        checkOutput({tag, ".piece"}, int'(bus.piece), int'(ePiece));
        checkOutput({tag, ".piece_valid"}, int'(bus.piece_valid), int'(ePv));
        checkOutput({tag, ".preview"}, int'(bus.preview), int'(ePrev));
        checkOutput({tag, ".preview_valid"}, int'(bus.preview_valid), int'(ePrevV));
        checkOutput({tag, ".fill_count"}, int'(bus.fill_count), int'(eCnt));
    endtask

    // Drive inputs just after an edge, then let one edge consume them.
    task automatic applyStimulus(input logic [1:0] rnd, input logic clr, input logic tk);
        bus.random = rnd;
        bus.clear  = clr;
        bus.take   = tk;
        @(posedge clka);
        #1;
    endtask

    task automatic doReset();
        restart    = 1'b1;
        bus.random = 2'd0;
        bus.clear  = 1'b0;
        bus.take   = 1'b0;
        @(posedge clka);
        #3;
        restart = 1'b0;
        @(posedge clka);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        restart  = 1'b1;
        bus.random = 2'd0;
        bus.clear  = 1'b0;
        bus.take   = 1'b0;

        //          rnd  clr   tk    piece pv    prev  prvV  cnt
        vecs[0]  = '{2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 3'd1};
        vecs[1]  = '{2'd1, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 3'd2};
        vecs[2]  = '{2'd2, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 3'd3};
        vecs[3]  = '{2'd3, 1'b0, 1'b0, 2'd0, 1'b1, 2'd1, 1'b1, 3'd4};
        vecs[4]  = '{2'd1, 1'b0, 1'b1, 2'd1, 1'b1, 2'd2, 1'b1, 3'd3};
        vecs[5]  = '{2'd1, 1'b0, 1'b0, 2'd1, 1'b1, 2'd2, 1'b1, 3'd4};
        vecs[6]  = '{2'd0, 1'b0, 1'b1, 2'd2, 1'b1, 2'd3, 1'b1, 3'd3};
        vecs[7]  = '{2'd0, 1'b0, 1'b1, 2'd3, 1'b1, 2'd1, 1'b1, 3'd3};
        vecs[8]  = '{2'd2, 1'b0, 1'b1, 2'd1, 1'b1, 2'd0, 1'b1, 3'd3};
        vecs[9]  = '{2'd3, 1'b1, 1'b1, 2'd0, 1'b0, 2'd0, 1'b0, 3'd0};
        vecs[10] = '{2'd3, 1'b0, 1'b1, 2'd0, 1'b0, 2'd0, 1'b0, 3'd1};
        vecs[11] = '{2'd3, 1'b0, 1'b1, 2'd0, 1'b0, 2'd0, 1'b0, 3'd2};
        vecs[12] = '{2'd3, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 3'd2};
        vecs[13] = '{2'd3, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 3'd2};
        vecs[14] = '{2'd3, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 3'd2};
        vecs[15] = '{2'd3, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 3'd3};
        vecs[16] = '{2'd1, 1'b0, 1'b0, 2'd3, 1'b1, 2'd3, 1'b1, 3'd4};

        #2;
        checkAll("reset", 2'd0, 1'b0, 2'd0, 1'b0, 3'd0);
        #5;
        restart = 1'b0;
        @(posedge clka);
        #1;
        checkAll("idle_after_reset", 2'd0, 1'b0, 2'd0, 1'b0, 3'd1);

        doReset();
        restart = 1'b1;
        #1;
        restart = 1'b0;
        #1;
        for (int i = 0; i < 17; i++) begin
            applyStimulus(vecs[i].rnd, vecs[i].clr, vecs[i].tk);
            checkAll($sformatf("vec%0d", i), vecs[i].ePiece, vecs[i].ePv,
                     vecs[i].ePrev, vecs[i].ePrevV, vecs[i].eCnt);
        end

        // Held value: 2,2 accepted, three rejects, forced 3, then 2.
        restart = 1'b1;
        #1;
        restart = 1'b0;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(2'd2, 1'b0, 1'b0);
        end
        checkOutput("held.pv_before_edge7", int'(bus.piece_valid), 0);
        checkOutput("held.cnt_before_edge7", int'(bus.fill_count), 3);
        applyStimulus(2'd2, 1'b0, 1'b0);
        checkAll("held.full", 2'd2, 1'b1, 2'd2, 1'b1, 3'd4);
        applyStimulus(2'd0, 1'b0, 1'b1);
        checkAll("held.pop1", 2'd2, 1'b1, 2'd3, 1'b1, 3'd3);
        applyStimulus(2'd0, 1'b0, 1'b1);
        checkAll("held.pop2", 2'd3, 1'b1, 2'd2, 1'b1, 3'd3);

        // Asynchronous reset mid-fill.
        restart = 1'b1;
        #1;
        restart = 1'b0;
        applyStimulus(2'd0, 1'b0, 1'b0);
        applyStimulus(2'd1, 1'b0, 1'b0);
        checkOutput("midfill.cnt", int'(bus.fill_count), 2);
        #2;
        restart = 1'b1;
        #1;
        checkAll("async_reset", 2'd0, 1'b0, 2'd0, 1'b0, 3'd0);
        #1;
        restart = 1'b0;
        applyStimulus(2'd1, 1'b0, 1'b0);
        checkAll("refill_start", 2'd0, 1'b0, 2'd0, 1'b0, 3'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
